// File: rtl/emulate_axi_master.sv
// emulate_axi_master: single-outstanding AXI4 burst initiator bridging AXI-stream ports to AXI MM.
// Rev 1.0
`default_nettype none

module emulate_axi_master #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 512,
   localparam int STRB_W = DATA_W / 8
) (
   input  logic              ap_clk,
   input  logic              ap_rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [7:0]        cmd_len,
   input  logic [DATA_W-1:0] s_axis_tdata,
   input  logic              s_axis_tvalid,
   output logic              s_axis_tready,
   output logic [DATA_W-1:0] m_axis_tdata,
   output logic              m_axis_tvalid,
   input  logic              m_axis_tready,
   output logic              m_axis_tlast,
   output logic [ADDR_W-1:0] axi_awaddr,
   output logic [7:0]        axi_awlen,
   output logic [2:0]        axi_awsize,
   output logic [1:0]        axi_awburst,
   output logic              axi_awvalid,
   input  logic              axi_awready,
   output logic [DATA_W-1:0] axi_wdata,
   output logic [STRB_W-1:0] axi_wstrb,
   output logic              axi_wlast,
   output logic              axi_wvalid,
   input  logic              axi_wready,
   input  logic [1:0]        axi_bresp,
   input  logic              axi_bvalid,
   output logic              axi_bready,
   output logic [ADDR_W-1:0] axi_araddr,
   output logic [7:0]        axi_arlen,
   output logic [2:0]        axi_arsize,
   output logic [1:0]        axi_arburst,
   output logic              axi_arvalid,
   input  logic              axi_arready,
   input  logic [DATA_W-1:0] axi_rdata,
   input  logic [1:0]        axi_rresp,
   input  logic              axi_rlast,
   input  logic              axi_rvalid,
   output logic              axi_rready,
   output logic              done,
   output logic              err
);

   localparam logic [2:0] SIZE = 3'($clog2(STRB_W));

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_AW   = 3'd1,
      S_W    = 3'd2,
      S_B    = 3'd3,
      S_AR   = 3'd4,
      S_R    = 3'd5
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [ADDR_W-1:0] addr_q;
   logic [7:0]        len_q;
   logic [7:0]        beat_cnt;
   logic              last_beat;
   logic              w_hs;
   logic              r_hs;
   logic              b_hs;

   assign last_beat = (beat_cnt == len_q);
   assign w_hs      = (state == S_W) && s_axis_tvalid && axi_wready;
   assign r_hs      = (state == S_R) && axi_rvalid && m_axis_tready;
   assign b_hs      = (state == S_B) && axi_bvalid;

   assign axi_awaddr   = addr_q;
   assign axi_awlen    = len_q;
   assign axi_awsize   = SIZE;
   assign axi_awburst  = 2'b01;
   assign axi_araddr   = addr_q;
   assign axi_arlen    = len_q;
   assign axi_arsize   = SIZE;
   assign axi_arburst  = 2'b01;
   assign axi_wdata    = s_axis_tdata;
   assign axi_wstrb    = '1;
   assign axi_wlast    = last_beat;
   assign m_axis_tdata = axi_rdata;
   assign m_axis_tlast = last_beat;

   // Handshake signals are decoded straight from state so reset drops them in the same cycle.
   always_comb begin
      state_next    = state;
      cmd_ready     = 1'b0;
      axi_awvalid   = 1'b0;
      axi_wvalid    = 1'b0;
      s_axis_tready = 1'b0;
      axi_bready    = 1'b0;
      axi_arvalid   = 1'b0;
      axi_rready    = 1'b0;
      m_axis_tvalid = 1'b0;
      case (state)
         S_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) state_next = cmd_write ? S_AW : S_AR;
         end
         S_AW: begin
            axi_awvalid = 1'b1;
            if (axi_awready) state_next = S_W;
         end
         S_W: begin
            axi_wvalid    = s_axis_tvalid;
            s_axis_tready = axi_wready;
            if (w_hs && last_beat) state_next = S_B;
         end
         S_B: begin
            axi_bready = 1'b1;
            if (axi_bvalid) state_next = S_IDLE;
         end
         S_AR: begin
            axi_arvalid = 1'b1;
            if (axi_arready) state_next = S_R;
         end
         S_R: begin
            m_axis_tvalid = axi_rvalid;
            axi_rready    = m_axis_tready;
            if (r_hs && last_beat) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state    <= S_IDLE;
         addr_q   <= '0;
         len_q    <= '0;
         beat_cnt <= '0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         state <= state_next;
         done  <= b_hs || (r_hs && last_beat);
         if (state == S_IDLE && cmd_valid) begin
            addr_q   <= cmd_addr;
            len_q    <= cmd_len;
            beat_cnt <= '0;
            err      <= 1'b0;
         end
         // Wrap after beat 255 is harmless: the burst has already exited on that beat.
         if (w_hs || r_hs) beat_cnt <= beat_cnt + 8'd1;
         if (b_hs && axi_bresp != 2'b00) err <= 1'b1;
         if (r_hs && (axi_rresp != 2'b00 || axi_rlast != last_beat)) err <= 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_emulate_axi_master.sv
// tb_emulate_axi_master: randomized self-checking bench with a transaction-level slave/stream model.
// Rev 1.0
`default_nettype none

module tb_emulate_axi_master;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int STRB_W = DATA_W / 8;

   logic              ap_clk = 1'b0;
   logic              ap_rst_n = 1'b0;
   logic              cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
   logic [ADDR_W-1:0] cmd_addr = '0;
   logic [7:0]        cmd_len = '0;
   logic [DATA_W-1:0] s_axis_tdata = '0, m_axis_tdata;
   logic              s_axis_tvalid = 1'b0, s_axis_tready;
   logic              m_axis_tvalid, m_axis_tready = 1'b0, m_axis_tlast;
   logic [ADDR_W-1:0] axi_awaddr, axi_araddr;
   logic [7:0]        axi_awlen, axi_arlen;
   logic [2:0]        axi_awsize, axi_arsize;
   logic [1:0]        axi_awburst, axi_arburst;
   logic              axi_awvalid, axi_awready = 1'b0;
   logic [DATA_W-1:0] axi_wdata;
   logic [STRB_W-1:0] axi_wstrb;
   logic              axi_wlast, axi_wvalid, axi_wready = 1'b0;
   logic [1:0]        axi_bresp = '0;
   logic              axi_bvalid = 1'b0, axi_bready;
   logic              axi_arvalid, axi_arready = 1'b0;
   logic [DATA_W-1:0] axi_rdata = '0;
   logic [1:0]        axi_rresp = '0;
   logic              axi_rlast = 1'b0, axi_rvalid = 1'b0, axi_rready;
   logic              done, err;

   int n_tests = 0;
   int n_fail  = 0;

   emulate_axi_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .m_axis_tlast(m_axis_tlast),
      .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
      .axi_awburst(axi_awburst), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
      .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
      .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
      .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
      .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
      .axi_arburst(axi_arburst), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
      .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
      .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
      .done(done), .err(err)
   );

   always #5 ap_clk = ~ap_clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   task automatic idle_inputs();
      cmd_valid = 1'b0;  axi_awready = 1'b0; axi_wready = 1'b0; s_axis_tvalid = 1'b0;
      axi_bvalid = 1'b0; axi_arready = 1'b0; axi_rvalid = 1'b0; m_axis_tready = 1'b0;
      axi_rlast = 1'b0;  axi_rresp = 2'b00;  axi_bresp = 2'b00;
   endtask

   task automatic accept(input logic wr, input logic [31:0] addr, input logic [7:0] len);
      @(negedge ap_clk);
      check("cmd_ready_idle", cmd_ready, 1);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
      @(posedge ap_clk);
      @(negedge ap_clk);
      cmd_valid = 1'b0;
      check("err_clear_on_accept", err, 0);
   endtask

   task automatic hold_idle(input bit exp_err);
      idle_inputs();
      repeat (2) begin
         @(negedge ap_clk);
         check("err_hold", err, exp_err);
         check("done_pulse", done, 0);
      end
   endtask

   // base < 0 gives random beat data; otherwise beat i carries base+i.
   task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] bresp,
                           input bit rnd, input int base, input int abort_at);
      logic [31:0] beats[$];
      int  sent = 0;
      int  cyc  = 1;
      bit  aw_done = 0, b_done = 0, aw_hs, w_hs;
      for (int i = 0; i <= int'(len); i++) beats.push_back(base < 0 ? $urandom : 32'(base + i));
      accept(1'b1, addr, len);
      while (!b_done && cyc < 3000) begin
         axi_awready   = rnd ? (($urandom % 4) != 0) : 1'b1;
         axi_wready    = rnd ? (($urandom % 4) != 0) : 1'b1;
         s_axis_tvalid = rnd ? (($urandom % 4) != 0) : 1'b1;
         s_axis_tdata  = (sent <= int'(len)) ? beats[sent] : '0;
         axi_bvalid    = rnd ? (($urandom % 3) != 0) : 1'b1;
         axi_bresp     = bresp;
         #1;
         if (cyc == 1) check("awvalid_n1", axi_awvalid, 1);
         check("done_busy", done, 0);
         check("cmd_ready_busy", cmd_ready, 0);
         if (aw_done) check("aw_single", axi_awvalid, 0);
         if (axi_awvalid) begin
            check("awaddr", axi_awaddr, addr);
            check("awlen", axi_awlen, len);
            check("awsize", axi_awsize, 3'd2);
            check("awburst", axi_awburst, 2'b01);
         end
         if (!aw_done) check("w_gated", {axi_wvalid, s_axis_tready}, 0);
         else if (sent <= int'(len)) begin
            check("wvalid_pass", axi_wvalid, s_axis_tvalid);
            check("tready_pass", s_axis_tready, axi_wready);
            check("bready_early", axi_bready, 0);
            if (axi_wvalid) begin
               check("wdata", axi_wdata, beats[sent]);
               check("wlast", axi_wlast, sent == int'(len));
               check("wstrb", axi_wstrb, 4'hF);
            end
         end
         if (abort_at >= 0 && aw_done && sent == abort_at && axi_wvalid) begin
            ap_rst_n = 1'b0;
            #1;
            check("rst_wvalid", axi_wvalid, 0);
            check("rst_tready", s_axis_tready, 0);
            check("rst_cmd_ready", cmd_ready, 1);
            check("rst_err", err, 0);
            return;
         end
         if (axi_bvalid && axi_bready) begin
            check("b_after_all_w", sent, int'(len) + 1);
            b_done = 1;
         end
         aw_hs = axi_awvalid && axi_awready;
         w_hs  = axi_wvalid && axi_wready;
         if (aw_hs) aw_done = 1;
         if (w_hs) sent++;
         @(negedge ap_clk);
         cyc++;
      end
      if (!b_done) check("write_timeout", 0, 1);
      check("write_done", done, 1);
      check("write_err", err, bresp != 2'b00);
      check("write_cmd_ready", cmd_ready, 1);
      if (!rnd) check("write_latency", cyc, int'(len) + 4);
      hold_idle(bresp != 2'b00);
   endtask

   // mode: 0 always ready, 1 random handshakes, 2 rvalid high with m_axis_tready toggling.
   task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input int mode,
                          input int rlast_idx, input int rresp_bad, input int base);
      logic [31:0] beats[$];
      int  idx = 0;
      int  cyc = 1;
      bit  ar_done = 0, r_done = 0, exp_err = 0, ar_hs, r_hs;
      for (int i = 0; i <= int'(len); i++) beats.push_back(base < 0 ? $urandom : 32'(base + i));
      accept(1'b0, addr, len);
      while (!r_done && cyc < 3000) begin
         axi_arready   = (mode == 1) ? (($urandom % 4) != 0) : 1'b1;
         axi_rvalid    = ar_done && ((mode == 1) ? (($urandom % 4) != 0) : 1'b1);
         axi_rdata     = beats[idx];
         axi_rlast     = (idx == rlast_idx);
         axi_rresp     = (idx == rresp_bad) ? 2'b10 : 2'b00;
         m_axis_tready = (mode == 0) ? 1'b1 : (mode == 1) ? (($urandom % 3) != 0) : 1'(cyc % 2);
         #1;
         if (cyc == 1) check("arvalid_n1", axi_arvalid, 1);
         check("done_busy", done, 0);
         check("cmd_ready_busy", cmd_ready, 0);
         if (ar_done) check("ar_single", axi_arvalid, 0);
         if (axi_arvalid) begin
            check("araddr", axi_araddr, addr);
            check("arlen", axi_arlen, len);
            check("arsize", axi_arsize, 3'd2);
            check("arburst", axi_arburst, 2'b01);
         end
         if (!ar_done) check("r_gated", {m_axis_tvalid, axi_rready}, 0);
         else begin
            check("tvalid_pass", m_axis_tvalid, axi_rvalid);
            check("rready_pass", axi_rready, m_axis_tready);
            if (m_axis_tvalid) begin
               check("tdata", m_axis_tdata, beats[idx]);
               check("tlast", m_axis_tlast, idx == int'(len));
            end
         end
         ar_hs = axi_arvalid && axi_arready;
         r_hs  = axi_rvalid && axi_rready;
         if (r_hs) begin
            if (axi_rresp != 2'b00 || axi_rlast != (idx == int'(len))) exp_err = 1;
            idx++;
            if (idx == int'(len) + 1) r_done = 1;
         end
         if (ar_hs) ar_done = 1;
         @(negedge ap_clk);
         cyc++;
      end
      if (!r_done) check("read_timeout", 0, 1);
      axi_rvalid = 1'b0;
      #1;
      check("read_done", done, 1);
      check("read_err", err, exp_err);
      check("read_cmd_ready", cmd_ready, 1);
      check("read_tvalid_idle", m_axis_tvalid, 0);
      if (mode == 0) check("read_latency", cyc, int'(len) + 3);
      hold_idle(exp_err);
   endtask

   initial begin
      idle_inputs();
      repeat (3) @(negedge ap_clk);
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_valids", {axi_awvalid, axi_wvalid, s_axis_tready, axi_bready,
                           axi_arvalid, axi_rready, m_axis_tvalid}, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      ap_rst_n = 1'b1;

      do_write(32'h1000, 8'd3, 2'b00, 1'b0, 32'hA0, -1);
      do_read(32'h2000, 8'd7, 2, 7, -1, 0);
      do_write(32'h3000, 8'd2, 2'b10, 1'b0, -1, -1);
      do_read(32'h4000, 8'd2, 0, 1, -1, -1);
      do_read(32'h5000, 8'd255, 0, 255, -1, -1);
      do_write(32'h0, 8'd0, 2'b00, 1'b0, -1, -1);
      do_read(32'h40, 8'd0, 0, 0, -1, -1);

      do_write(32'h6000, 8'd7, 2'b00, 1'b0, -1, 2);
      idle_inputs();
      @(negedge ap_clk);
      check("rst_hold_cmd_ready", cmd_ready, 1);
      ap_rst_n = 1'b1;
      @(negedge ap_clk);
      check("post_rst_cmd_ready", cmd_ready, 1);
      check("post_rst_awvalid", axi_awvalid, 0);
      check("post_rst_done", done, 0);
      do_read(32'h7000, 8'd3, 0, 3, -1, 32'h70);

      for (int t = 0; t < 12; t++) begin
         logic [7:0] len;
         len = 8'($urandom % 16);
         if ($urandom % 2) begin
            do_write($urandom & 32'hFFFF_FFC0, len, (($urandom % 4) == 0) ? 2'(1 + $urandom % 3) : 2'b00,
                     1'b1, -1, -1);
         end else begin
            do_read($urandom & 32'hFFFF_FFC0, len, 1,
                    (($urandom % 4) == 0) ? int'($urandom % 17) : int'(len),
                    (($urandom % 4) == 0) ? int'($urandom % 17) : -1, -1);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/emulate_axi_master.md
# emulate_axi_master

AXI4 memory-mapped burst initiator for CGRA test benches: accepts a single read or write command, issues the AR or AW burst, and moves data beats between AXI-stream ports and the AXI data channels. It pairs with the emulated AXI responder and stream emulators on the bench side, so CGRA data paths run against a real initiator. One transaction is outstanding at a time.

## Interface

Parameters:
- ADDR_W, 64, address width
- DATA_W, 512, data width in bits; equals phit_size
- Derived: STRB_W = DATA_W/8; SIZE = log2(DATA_W/8), driven on axsize

Ports:
- ap_clk  in  1  sole clock; everything is on the rising edge
- ap_rst_n  in  1  asynchronous, active-low reset
- cmd_valid / cmd_ready  in / out  1 / 1  command handshake
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  ADDR_W  burst start address
- cmd_len  in  8  AXI len, beats minus 1
- s_axis_tdata / tvalid / tready  in / in / out  DATA_W / 1 / 1  write-data source
- m_axis_tdata / tvalid / tready / tlast  out / out / in / out  DATA_W / 1 / 1 / 1  read-data sink
- axi_awaddr, awlen, awsize, awburst, awvalid  out  ADDR_W, 8, 3, 2, 1
- axi_awready  in  1
- axi_wdata, wstrb, wlast, wvalid  out  DATA_W, STRB_W, 1, 1
- axi_wready  in  1
- axi_bresp, bvalid  in  2, 1
- axi_bready  out  1
- axi_araddr, arlen, arsize, arburst, arvalid  out  ADDR_W, 8, 3, 2, 1
- axi_arready  in  1
- axi_rdata, rresp, rlast, rvalid  in  DATA_W, 2, 1, 1
- axi_rready  out  1
- done  out  1  one-cycle pulse at transaction end
- err  out  1  sticky error flag; cleared when the next command is accepted

## Operation

- States: IDLE, AW, W, B, AR, R. A 2-bit state register is not enough; use 3 bits.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, the block latches addr and len, clears beat_cnt and err, then goes to AW if cmd_write = 1, otherwise to AR.
- AW:
  - awvalid = 1, awaddr and awlen come from the latched values.
  - On awready, go to W.
- W:
  - wvalid = s_axis_tvalid, s_axis_tready = wready, wdata = s_axis_tdata.
  - wstrb is all ones. wlast = (beat_cnt == len).
  - beat_cnt increments on each W handshake. The handshake carrying wlast moves to B.
- B:
  - bready = 1.
  - On bvalid, set err if bresp != 2'b00, then go to IDLE.
- AR:
  - arvalid = 1.
  - On arready, go to R.
- R:
  - m_axis_tvalid = rvalid, rready = m_axis_tready, m_axis_tdata = rdata.
  - m_axis_tlast = (beat_cnt == len).
  - On each handshake, set err if rresp != 0, or rlast != (beat_cnt == len).
  - The handshake with beat_cnt == len goes to IDLE, even if rlast was missing.
- Fixed outputs in all states: awburst = arburst = 2'b01 (INCR); awsize = arsize = SIZE.
- Outside their state, every valid/ready output is 0: awvalid, wvalid, s_axis_tready, bready, arvalid, rready, m_axis_tvalid.
- Data outputs are don't-care while their valid is low.
- The block does not split bursts at 4 KB boundaries. Callers supply legal bursts.
- Once asserted, AW/AR valid holds with stable address and len until the handshake completes.
- beat_cnt is 8 bits. len = 255 gives 256 beats with no overflow, because the exit occurs at beat_cnt == 255.

## Timing

- Reset (asynchronous): state = IDLE, beat_cnt = 0, done = 0, err = 0, all valids and readies = 0 except cmd_ready = 1.
- Reset asserted mid-burst aborts immediately: valids drop in the same cycle, and no B or R completion is expected.
- Cmd accept in cycle N → awvalid or arvalid high in cycle N+1.
- Data-channel pass-through is combinational, with zero added latency.
- done is registered. It is high in the cycle after the final B or R handshake, which is the same cycle state is IDLE.
- Since cmd_ready is high in that cycle, back-to-back commands are possible.
- Minimum write with len = 0 and an always-ready slave: accept N, AW N+1, W N+2, B N+3, done N+4.
- Minimum read with len = 0: accept N, AR N+1, R N+2, done N+3.
- err updates on the handshake edge and holds through done until the next accept.
- cmd_valid while not in IDLE is ignored, because cmd_ready = 0.

## Test plan

- Write, addr 0x1000, len 3, slave always ready, stream beats 0xA0..0xA3 → one AW with awlen 3; four W beats with wlast only on 0xA3; done at N+7; err = 0.
- Read, addr 0x2000, len 7, slave returns 0..7 with rlast on beat 7, m_axis_tready toggling every cycle → m_axis gets 0..7 in order with tlast on 7; no beat lost or duplicated.
- Write with bresp = 2'b10 → err = 1 at done and stays 1 until the next accept, where it clears.
- Read len 2 with rlast asserted on beat 1 → err = 1; the block still consumes 3 beats and returns to IDLE.
- Read len 255 → 256 beats, tlast on the last beat, beat_cnt does not wrap early.
- ap_rst_n pulsed low during W beat 2 of a len 7 write → wvalid and s_axis_tready go low asynchronously; cmd_ready = 1 after release; a new read then completes normally.
